// File: rtl/can_bit_timing.sv
// can_bit_timing: CAN bit timing unit (prescaler, SYNC/TSEG1/TSEG2 sequencing, hard sync, resync).
// Define CAN_TRIPLE_SAMPLE_EN for majority-of-three sampling at the sample point.
module can_bit_timing #(
    parameter int BRP_W   = 6,
    parameter int TSEG1_W = 4,
    parameter int TSEG2_W = 3,
    parameter int SJW_W   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [BRP_W-1:0]   brp,
    input  logic [TSEG1_W-1:0] tseg1,
    input  logic [TSEG2_W-1:0] tseg2,
    input  logic [SJW_W-1:0]   sjw,
    input  logic               hard_sync_en,
    input  logic               rx,
    output logic               tq_tick,
    output logic               bit_start,
    output logic               sample_tick,
    output logic               sampled_bit,
    output logic [1:0]         seg
);

    localparam int MW = (TSEG1_W > TSEG2_W) ? TSEG1_W : TSEG2_W;
    localparam int CW = ((MW > SJW_W) ? MW : SJW_W) + 1;

    typedef enum logic [1:0] {SYNC = 2'd0, TSEG1 = 2'd1, TSEG2 = 2'd2} seg_t;

    seg_t               seg_q, seg_n;
    logic [BRP_W-1:0]   presc_q, presc_n, brp_l, brp_e;
    logic [TSEG1_W-1:0] t1_l, t1_r;
    logic [TSEG2_W-1:0] t2_l, t2_r;
    logic [SJW_W-1:0]   sjw_l, sjw_r;
    logic [CW-1:0]      cnt_q, cnt_n, ext_q, ext_n, ext_d, len2_q, len2_n, len2_d;
    logic [CW-1:0]      t1e, t2e, sjwe, sjw_eff, t2m, len1;
    logic               run_q, run_n, started_q, started_n, synced_q, synced_n;
    logic               rx_q, sampled_q, sampled_n, samp_val;
    logic               active, edge_det, hs, tick, rs, bs, st;

`ifdef CAN_TRIPLE_SAMPLE_EN
    logic [1:0] hist_q;
    assign samp_val = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx) | (hist_q[0] & rx);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            hist_q <= 2'b11;
        else if (tick)
            hist_q <= {hist_q[0], rx};
    end
`else
    assign samp_val = rx;
`endif

    // Live inputs govern until the first bit_start (or hard sync) latches a bit's config
    always_comb begin
        brp_e    = run_q ? brp_l : brp;
        t1_r     = run_q ? t1_l : tseg1;
        t2_r     = run_q ? t2_l : tseg2;
        sjw_r    = run_q ? sjw_l : sjw;
        t1e      = (t1_r == '0) ? CW'(1) : CW'(t1_r);
        t2e      = (t2_r == '0) ? CW'(1) : CW'(t2_r);
        sjwe     = (sjw_r == '0) ? CW'(1) : CW'(sjw_r);
        sjw_eff  = (sjwe < t2e) ? sjwe : t2e;
        t2m      = t2e - sjw_eff;
        active   = rst_n & en;
        edge_det = active & ~rx & rx_q;
        hs       = edge_det & hard_sync_en;
        tick     = active & (presc_q == brp_e) & ~hs;
        rs       = edge_det & ~hard_sync_en & started_q & ~synced_q;
        // Phase corrections apply in the edge cycle itself so a coincident tick sees them
        ext_n    = (rs && seg_q == TSEG1) ? ((cnt_q < sjw_eff) ? cnt_q : sjw_eff) : ext_q;
        len1     = t1e + ext_n;
        len2_n   = (rs && seg_q == TSEG2) ? ((t2m > cnt_q) ? t2m : cnt_q) : len2_q;
        bs       = tick & (~started_q | (seg_q == TSEG2 && cnt_q >= len2_n));
        st       = tick & (seg_q == TSEG1) & (cnt_q >= len1);
    end

    always_comb begin
        seg_n     = seg_q;
        cnt_n     = cnt_q;
        ext_d     = ext_n;
        len2_d    = len2_n;
        presc_n   = presc_q + 1'b1;
        started_n = started_q;
        synced_n  = synced_q | (edge_det & started_q);
        run_n     = run_q | bs | hs;
        sampled_n = st ? samp_val : sampled_q;
        if (!en) begin
            presc_n   = '0;
            seg_n     = SYNC;
            cnt_n     = '0;
            ext_d     = '0;
            len2_d    = '0;
            started_n = 1'b0;
            synced_n  = 1'b0;
            run_n     = 1'b0;
        end else if (hs) begin
            presc_n   = '0;
            seg_n     = TSEG1;
            cnt_n     = CW'(1);
            ext_d     = '0;
            started_n = 1'b1;
            synced_n  = 1'b1;
        end else if (tick) begin
            presc_n = '0;
            if (bs) begin
                seg_n     = SYNC;
                cnt_n     = '0;
                ext_d     = '0;
                started_n = 1'b1;
                synced_n  = 1'b0;
            end else if (seg_q == SYNC) begin
                seg_n = TSEG1;
                cnt_n = CW'(1);
            end else if (st) begin
                seg_n  = TSEG2;
                cnt_n  = CW'(1);
                len2_d = t2e;
            end else begin
                cnt_n = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q     <= SYNC;
            presc_q   <= '0;
            cnt_q     <= '0;
            ext_q     <= '0;
            len2_q    <= '0;
            run_q     <= 1'b0;
            started_q <= 1'b0;
            synced_q  <= 1'b0;
            rx_q      <= 1'b1;
            sampled_q <= 1'b1;
            brp_l     <= '0;
            t1_l      <= '0;
            t2_l      <= '0;
            sjw_l     <= '0;
        end else begin
            seg_q     <= seg_n;
            presc_q   <= presc_n;
            cnt_q     <= cnt_n;
            ext_q     <= ext_d;
            len2_q    <= len2_d;
            run_q     <= run_n;
            started_q <= started_n;
            synced_q  <= synced_n;
            rx_q      <= rx;
            sampled_q <= sampled_n;
            if (bs | hs) begin
                brp_l <= brp;
                t1_l  <= tseg1;
                t2_l  <= tseg2;
                sjw_l <= sjw;
            end
        end
    end

    assign tq_tick     = tick;
    assign bit_start   = bs;
    assign sample_tick = st;
    assign sampled_bit = sampled_q;
    assign seg         = seg_q;

endmodule

// File: tb/tb_can_bit_timing.sv
// tb_can_bit_timing: directed bench for can_bit_timing; timings measured in clock cycles.
module tb_can_bit_timing;

    logic       clk = 1'b0, rst_n = 1'b0, en = 1'b0, hard_sync_en = 1'b0, rx = 1'b1;
    logic [5:0] brp = 6'd3;
    logic [3:0] tseg1 = 4'd5;
    logic [2:0] tseg2 = 3'd2;
    logic [1:0] sjw = 2'd1;
    logic       tq_tick, bit_start, sample_tick, sampled_bit;
    logic [1:0] seg;
    int         cyc = 0, vectors = 0, miscompares = 0, last_st = -1;
    logic       triple_exp;

    can_bit_timing dut (
        .clk(clk), .rst_n(rst_n), .en(en), .brp(brp), .tseg1(tseg1), .tseg2(tseg2),
        .sjw(sjw), .hard_sync_en(hard_sync_en), .rx(rx), .tq_tick(tq_tick),
        .bit_start(bit_start), .sample_tick(sample_tick), .sampled_bit(sampled_bit), .seg(seg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (sample_tick === 1'b1) last_st <= cyc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic go_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic pulse_rx(input int t);
        go_to(t);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic wait_ev(input string tag, input bit want_bs, input int lim, output int t);
        bit found = 1'b0;
        t = -1;
        for (int n = 0; n < lim && !found; n++) begin
            @(negedge clk);
            #1;
            if ((want_bs ? bit_start : sample_tick) === 1'b1) begin
                found = 1'b1;
                t = cyc;
            end
        end
        if (!found) chk({tag, "_timeout"}, found, 1);
    endtask

    initial begin
        int c, t0, t1, ts, te;
`ifdef CAN_TRIPLE_SAMPLE_EN
        triple_exp = 1'b0;
`else
        triple_exp = 1'b1;
`endif
        repeat (2) @(negedge clk);
        chk("rst_tq_tick", tq_tick, 0);
        chk("rst_bit_start", bit_start, 0);
        chk("rst_sample_tick", sample_tick, 0);
        chk("rst_sampled_bit", sampled_bit, 1);
        chk("rst_seg", seg, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_tq_tick", tq_tick, 0);
        chk("idle_seg", seg, 0);
        // nominal: brp=3 tseg1=5 tseg2=2
        en = 1'b1;
        c = cyc;
        wait_ev("first_bs", 1, 20, t0);
        chk("first_bs_delay", t0 - c, 3);
        wait_ev("nom_sp", 0, 40, ts);
        chk("nom_sample", ts - t0, 24);
        chk("seg_at_sample", seg, 1);
        @(negedge clk);
        chk("sampled_hi", sampled_bit, 1);
        wait_ev("nom_bs", 1, 40, t1);
        chk("nom_period", t1 - t0, 32);
        chk("seg_at_bs", seg, 2);
        // late edge at TSEG1 tq 2, sjw=1
        go_to(t1 + 10);
        rx = 1'b0;
        wait_ev("late_sp", 0, 40, ts);
        chk("late_sample", ts - t1, 28);
        @(negedge clk);
        chk("sampled_lo", sampled_bit, 0);
        rx = 1'b1;
        wait_ev("late_bs", 1, 40, t0);
        chk("late_period", t0 - t1, 36);
        @(negedge clk);
        sjw = 2'd2;
        wait_ev("nom2_bs", 1, 40, t1);
        chk("nom_period2", t1 - t0, 32);
        // early edge in first TSEG2 tq, sjw=2
        pulse_rx(t1 + 26);
        wait_ev("early_bs", 1, 40, t0);
        chk("early_period", t0 - t1, 28);
        // two TSEG1 edges in one bit: only the first adjusts
        pulse_rx(t0 + 6);
        pulse_rx(t0 + 14);
        wait_ev("one_sp", 0, 40, ts);
        chk("one_resync_sample", ts - t0, 28);
        wait_ev("one_bs", 1, 40, t1);
        chk("one_resync_period", t1 - t0, 36);
        pulse_rx(t1 + 2);
        wait_ev("sync_bs", 1, 40, t0);
        chk("sync_edge_period", t0 - t1, 32);
        // config change mid-bit applies to the following bit
        go_to(t0 + 5);
        tseg1 = 4'd3;
        wait_ev("cfg_old_bs", 1, 40, t1);
        chk("old_cfg_period", t1 - t0, 32);
        wait_ev("cfg_sp", 0, 40, ts);
        chk("new_cfg_sample", ts - t1, 16);
        tseg1 = 4'd5;
        wait_ev("cfg_new_bs", 1, 40, t0);
        chk("new_cfg_period", t0 - t1, 24);
        // hard sync mid-TSEG1
        @(negedge clk);
        hard_sync_en = 1'b1;
        te = t0 + 14;
        pulse_rx(te);
        wait_ev("hs_bs", 1, 60, t1);
        chk("hs_next_bs", t1 - te, 28);
        chk("hs_sample", last_st - te, 20);
        hard_sync_en = 1'b0;
        // edge exactly on the nominal sample tick delays it by SJW
        go_to(t1 + 24);
        rx = 1'b0;
        wait_ev("sp_edge_sp", 0, 40, ts);
        chk("edge_at_sp_sample", ts - t1, 32);
        @(negedge clk);
        chk("sampled_lo2", sampled_bit, 0);
        repeat (2) @(negedge clk);
        chk("pre_rst_seg", seg, 2);
        rst_n = 1'b0;
        #1;
        chk("async_rst_seg", seg, 0);
        chk("async_rst_sampled", sampled_bit, 1);
        chk("async_rst_tq_tick", tq_tick, 0);
        chk("async_rst_bit_start", bit_start, 0);
        rx = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        c = cyc;
        wait_ev("post_rst_bs", 1, 20, t0);
        chk("post_rst_bs_delay", t0 - c, 3);
        // brp=0 with en rising
        en = 1'b0;
        brp = 6'd0;
        #1;
        chk("en_off_tq_tick", tq_tick, 0);
        repeat (2) @(negedge clk);
        chk("en_off_bit_start", bit_start, 0);
        en = 1'b1;
        c = cyc;
        #1;
        chk("fast_first_tick", tq_tick, 1);
        chk("fast_first_bs", bit_start, 1);
        go_to(c + 4);
        rx = 1'b0;
        #1;
        chk("fast_tick_c4", tq_tick, 1);
        go_to(c + 8);
        rx = 1'b1;
        #1;
        chk("fast_sample_c8", sample_tick, 1);
        @(negedge clk);
        chk("triple_sample", sampled_bit, triple_exp);
        wait_ev("fast_bs", 1, 20, t0);
        chk("fast_period", t0 - c, 10);
        en = 1'b0;
        #1;
        chk("final_en_off_tick", tq_tick, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
